// File: rtl/spike_step_sequencer_pkg.sv
// Shared definitions for the spike step sequencer slice: FSM state type,
// default configuration byte offsets, spike frame width and FIFO depth.
package spike_step_sequencer_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } seq_state_t;

    localparam int unsigned FRAME_W          = 8;
    localparam int unsigned FIFO_DEPTH       = 4;

    localparam int unsigned DEF_CLK_DIV_ADDR = 0;
    localparam int unsigned DEF_SPIKE_ADDR   = 1;
    localparam int unsigned DEF_DEBUG_ADDR   = 2;

    typedef logic [FRAME_W-1:0] frame_t;

endpackage

// File: rtl/spike_step_sequencer_flag_sync_edge.sv
// flag_sync_edge: multi-flop synchroniser for an asynchronous level flag,
// followed by a registered edge detector. rise/fall are single-cycle pulses
// derived only from flops, asserted in the cycle before the
// (SYNC_STAGES+1)th edge after the flag is first sampled high/low.
module flag_sync_edge #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic flag,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_chain;
    logic                   prev_level;

    if (SYNC_STAGES < 2) begin : g_bad_stages
        $error("flag_sync_edge: SYNC_STAGES must be at least 2");
    end

    // Shift the async flag through the synchroniser and remember the last synced level.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_chain <= '0;
            prev_level <= 1'b0;
        end else begin
            sync_chain <= {sync_chain[SYNC_STAGES-2:0], flag};
            prev_level <= sync_chain[SYNC_STAGES-1];
        end
    end

    assign rise = sync_chain[SYNC_STAGES-1] & ~prev_level;
    assign fall = ~sync_chain[SYNC_STAGES-1] & prev_level;

endmodule

// File: rtl/spike_step_sequencer.sv
// spike_step_sequencer: synchronises the SPI configuration ready flags,
// snapshots divider/spike/debug bytes and generates the SNN time-step tick,
// delivering one spike frame per step.
// Optional build macro: SPIKE_FIFO_EN (4-entry spike frame FIFO instead of a
// single overwrite-on-collision pending register).
module spike_step_sequencer
    import spike_step_sequencer_pkg::*;
#(
    parameter int unsigned NUM_BYTES    = 128,
    parameter int unsigned CLK_DIV_ADDR = DEF_CLK_DIV_ADDR,
    parameter int unsigned SPIKE_ADDR   = DEF_SPIKE_ADDR,
    parameter int unsigned DEBUG_ADDR   = DEF_DEBUG_ADDR,
    parameter int unsigned SYNC_STAGES  = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_BYTES*8-1:0] all_data_out,
    input  logic                   clk_div_ready,
    input  logic                   input_spike_ready,
    input  logic                   debug_config_ready,
    output logic                   step_en,
    output logic [FRAME_W-1:0]     spikes_out,
    output logic [7:0]             debug_config,
    output logic                   running,
    output logic                   overrun
);

    logic div_rise, div_fall;
    logic spike_rise, spike_fall;
    logic debug_rise, debug_fall;

    flag_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_div_sync (
        .clk   (clk),
        .reset (reset),
        .flag  (clk_div_ready),
        .rise  (div_rise),
        .fall  (div_fall)
    );

    flag_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_spike_sync (
        .clk   (clk),
        .reset (reset),
        .flag  (input_spike_ready),
        .rise  (spike_rise),
        .fall  (spike_fall)
    );

    flag_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_debug_sync (
        .clk   (clk),
        .reset (reset),
        .flag  (debug_config_ready),
        .rise  (debug_rise),
        .fall  (debug_fall)
    );

    frame_t div_byte, spike_byte, debug_byte;

    assign div_byte   = all_data_out[CLK_DIV_ADDR*8 +: 8];
    assign spike_byte = all_data_out[SPIKE_ADDR*8 +: 8];
    assign debug_byte = all_data_out[DEBUG_ADDR*8 +: 8];

    // Most of the image and the spike/debug fall pulses have no function here.
    logic unused_inputs;
    assign unused_inputs = ^{all_data_out, spike_fall, debug_fall};

    seq_state_t state;
    logic [7:0] div_shadow;
    logic [7:0] count;
    logic       step_fire;

    // A divider edge (restart or stop) always wins over a step in the same cycle.
    assign step_fire = (state == RUN) && (count == '0) && !div_rise && !div_fall;

    // Time-step FSM: start/restart on divider rise, stop on fall, count down in RUN.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            div_shadow <= '0;
            count      <= '0;
            running    <= 1'b0;
            step_en    <= 1'b0;
        end else begin
            step_en <= step_fire;
            if (div_rise) begin
                state      <= RUN;
                div_shadow <= div_byte;
                count      <= div_byte;
                running    <= 1'b1;
            end else if (div_fall) begin
                state   <= IDLE;
                running <= 1'b0;
            end else if (state == RUN) begin
                if (count == '0) begin
                    count <= div_shadow;
                end else begin
                    count <= count - 1'b1;
                end
            end
        end
    end

`ifdef SPIKE_FIFO_EN
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W:0] FILL_FULL = (PTR_W+1)'(FIFO_DEPTH);

    frame_t           fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] rd_ptr, wr_ptr;
    logic [PTR_W:0]   fill;
    logic             push, pop;

    // A step on an empty FIFO is silent even when a frame arrives in the same cycle.
    assign pop  = step_fire && (fill != '0);
    assign push = spike_rise && ((fill != FILL_FULL) || pop);

    // Spike frame FIFO: push on spike rise, pop on step, drop and flag when full.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            fill       <= '0;
            spikes_out <= '0;
            overrun    <= 1'b0;
        end else begin
            spikes_out <= '0;
            if (pop) begin
                spikes_out <= fifo_mem[rd_ptr];
                rd_ptr     <= rd_ptr + 1'b1;
            end
            if (push) begin
                fifo_mem[wr_ptr] <= spike_byte;
                wr_ptr           <= wr_ptr + 1'b1;
            end
            if (spike_rise && !push) begin
                overrun <= 1'b1;
            end
            fill <= fill + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
        end
    end
`else
    frame_t pending;
    logic   pending_valid;

    // Single pending frame: a step consumes the old frame before a same-cycle arrival lands.
    always_ff @(posedge clk) begin
        if (reset) begin
            pending       <= '0;
            pending_valid <= 1'b0;
            spikes_out    <= '0;
            overrun       <= 1'b0;
        end else begin
            spikes_out <= '0;
            if (step_fire) begin
                spikes_out    <= pending_valid ? pending : '0;
                pending_valid <= 1'b0;
            end
            if (spike_rise) begin
                pending       <= spike_byte;
                pending_valid <= 1'b1;
                if (pending_valid && !step_fire) begin
                    overrun <= 1'b1;
                end
            end
        end
    end
`endif

    // Debug byte is latched on each debug rise and held otherwise.
    always_ff @(posedge clk) begin
        if (reset) begin
            debug_config <= '0;
        end else if (debug_rise) begin
            debug_config <= debug_byte;
        end
    end

endmodule

// File: tb/tb_spike_step_sequencer.sv
// Self-checking bench for spike_step_sequencer. Reference model tracks step
// instants as absolute cycle numbers and pending frames as a queue.
// Honour SPIKE_FIFO_EN the same way the design does.
`timescale 1ns/1ps
module tb_spike_step_sequencer;

    localparam int unsigned NUM_BYTES = 128;
`ifdef SPIKE_FIFO_EN
    localparam int QCAP = 4;
`else
    localparam int QCAP = 1;
`endif

    logic                   clk = 1'b0;
    logic                   reset;
    logic [NUM_BYTES*8-1:0] all_data_out;
    logic                   clk_div_ready;
    logic                   input_spike_ready;
    logic                   debug_config_ready;
    logic                   step_en;
    logic [7:0]             spikes_out;
    logic [7:0]             debug_config;
    logic                   running;
    logic                   overrun;

    spike_step_sequencer #(
        .NUM_BYTES    (NUM_BYTES),
        .CLK_DIV_ADDR (0),
        .SPIKE_ADDR   (1),
        .DEBUG_ADDR   (2),
        .SYNC_STAGES  (2)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .all_data_out       (all_data_out),
        .clk_div_ready      (clk_div_ready),
        .input_spike_ready  (input_spike_ready),
        .debug_config_ready (debug_config_ready),
        .step_en            (step_en),
        .spikes_out         (spikes_out),
        .debug_config       (debug_config),
        .running            (running),
        .overrun            (overrun)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;
    int cyc    = 0;

    // Reference model state
    bit [3:0] h_div, h_spk, h_dbg;   // [0] = flag sampled at the latest edge
    bit       m_run;
    int       m_div;
    int       m_next;                // cycle number of the next step
    int       m_q[$];
    bit       m_ovr;
    int       m_dbg;
    bit       e_step;
    int       e_spk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    endtask

    function automatic int bus_byte(input int k);
        return int'(all_data_out[k*8 +: 8]);
    endfunction

    task automatic set_byte(input int k, input logic [7:0] v);
        all_data_out[k*8 +: 8] = v;
    endtask

    // One clock: advance the model on the edge, then compare every output.
    task automatic tick();
        bit dr, df, sr, dbr;
        @(posedge clk);
        cyc++;
        if (reset) begin
            h_div = '0; h_spk = '0; h_dbg = '0;
            m_run = 0; m_div = 0; m_next = 0; m_q.delete();
            m_ovr = 0; m_dbg = 0; e_step = 0; e_spk = 0;
        end else begin
            h_div = {h_div[2:0], clk_div_ready};
            h_spk = {h_spk[2:0], input_spike_ready};
            h_dbg = {h_dbg[2:0], debug_config_ready};
            dr  = h_div[2] && !h_div[3];
            df  = !h_div[2] && h_div[3];
            sr  = h_spk[2] && !h_spk[3];
            dbr = h_dbg[2] && !h_dbg[3];
            e_step = m_run && !dr && !df && (cyc == m_next);
            e_spk  = 0;
            if (e_step) begin
                if (m_q.size() > 0) e_spk = m_q.pop_front();
                m_next = cyc + m_div + 1;
            end
            if (dr) begin
                m_run  = 1;
                m_div  = bus_byte(0);
                m_next = cyc + m_div + 1;
            end else if (df) begin
                m_run = 0;
            end
            if (sr) begin
                if (m_q.size() < QCAP) m_q.push_back(bus_byte(1));
                else begin
                    m_ovr = 1;
                    if (QCAP == 1) m_q[0] = bus_byte(1);
                end
            end
            if (dbr) m_dbg = bus_byte(2);
        end
        #1;
        check_eq("step_en", step_en, e_step);
        check_eq("spikes_out", spikes_out, e_spk);
        check_eq("running", running, m_run);
        check_eq("overrun", overrun, m_ovr);
        check_eq("debug_config", debug_config, m_dbg);
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    task automatic gap_to_step(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!step_en && n < 600);
    endtask

    task automatic wait_running();
        int n = 0;
        do begin
            tick();
            n++;
        end while (!running && n < 20);
        check_eq("running_up", running, 1'b1);
    endtask

    task automatic expect_step(input string tag, input logic [7:0] frame);
        int n;
        gap_to_step(n);
        check_eq({tag, "_seen"}, step_en, 1'b1);
        check_eq(tag, spikes_out, frame);
    endtask

    task automatic stop_divider();
        clk_div_ready = 1'b0;
        run(5);
    endtask

    task automatic spike_pulse(input logic [7:0] v);
        set_byte(1, v);
        input_spike_ready = 1'b1;
        run(2);
        input_spike_ready = 1'b0;
        run(2);
    endtask

    initial begin
        int n;
        int steps;

        reset = 1'b1;
        clk_div_ready = 1'b0;
        input_spike_ready = 1'b0;
        debug_config_ready = 1'b0;
        for (int i = 0; i < int'(NUM_BYTES); i++) set_byte(i, 8'($urandom));
        run(3);
        reset = 1'b0;
        run(2);

        // Divider 3: period 4, first step 4 cycles after running
        set_byte(0, 8'd3);
        clk_div_ready = 1'b1;
        wait_running();
        gap_to_step(n);
        check_eq("div3_first_gap", n, 4);
        gap_to_step(n);
        check_eq("div3_period", n, 4);

        // Spike delivery then silent step
        set_byte(1, 8'hA5);
        input_spike_ready = 1'b1;
        expect_step("spike_a5", 8'hA5);
        input_spike_ready = 1'b0;
        expect_step("silent_after_a5", 8'h00);

        // Divider 0: step every cycle
        stop_divider();
        set_byte(0, 8'd0);
        clk_div_ready = 1'b1;
        wait_running();
        gap_to_step(n);
        check_eq("div0_first_gap", n, 1);
        for (int i = 0; i < 7; i++) begin
            tick();
            check_eq("div0_every_cycle", step_en, 1'b1);
        end

        // Divider 7, collision of spike rise with a step
        stop_divider();
        set_byte(0, 8'd7);
        clk_div_ready = 1'b1;
        wait_running();
        gap_to_step(n);
        check_eq("div7_first_gap", n, 8);
        set_byte(1, 8'hA5);
        input_spike_ready = 1'b1;
        tick();
        input_spike_ready = 1'b0;
        run(4);
        set_byte(1, 8'h3C);
        input_spike_ready = 1'b1;
        run(3);
        check_eq("collision_step", step_en, 1'b1);
        check_eq("collision_frame", spikes_out, 8'hA5);
        check_eq("collision_overrun", overrun, 1'b0);
        input_spike_ready = 1'b0;
        expect_step("collision_next", 8'h3C);
        check_eq("collision_next_overrun", overrun, 1'b0);

        // Two frames inside one step period
        set_byte(1, 8'h11);
        input_spike_ready = 1'b1;
        tick();
        input_spike_ready = 1'b0;
        run(2);
        set_byte(1, 8'h22);
        input_spike_ready = 1'b1;
        tick();
        input_spike_ready = 1'b0;
        run(4);
        check_eq("double_step", step_en, 1'b1);
        check_eq("double_frame", spikes_out, (QCAP == 1) ? 8'h22 : 8'h11);
        check_eq("double_overrun", overrun, (QCAP == 1) ? 1'b1 : 1'b0);
        expect_step("double_next", (QCAP == 1) ? 8'h00 : 8'h22);

        // Debug capture, then stop
        set_byte(2, 8'h5A);
        debug_config_ready = 1'b1;
        run(5);
        check_eq("debug_5a", debug_config, 8'h5A);
        stop_divider();
        check_eq("stopped", running, 1'b0);
        steps = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (step_en) steps++;
        end
        check_eq("no_step_after_stop", steps, 0);
        check_eq("debug_held", debug_config, 8'h5A);

        // Five frames without a step
        for (int i = 0; i < 5; i++) spike_pulse(8'($urandom));
        check_eq("full_overrun", overrun, 1'b1);

        // Reset in the middle of a run
        set_byte(0, 8'd9);
        clk_div_ready = 1'b1;
        wait_running();
        run(4);
        reset = 1'b1;
        clk_div_ready = 1'b0;
        input_spike_ready = 1'b0;
        debug_config_ready = 1'b0;
        tick();
        reset = 1'b0;
        check_eq("rst_step_en", step_en, 1'b0);
        check_eq("rst_spikes", spikes_out, 8'h00);
        check_eq("rst_running", running, 1'b0);
        check_eq("rst_overrun", overrun, 1'b0);
        check_eq("rst_debug", debug_config, 8'h00);
        steps = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (step_en) steps++;
        end
        check_eq("rst_no_steps", steps, 0);

        // Randomised traffic against the model
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 39) == 0) begin
                if (!clk_div_ready)
                    set_byte(0, ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 6)));
                clk_div_ready = ~clk_div_ready;
            end
            if ($urandom_range(0, 5) == 0) begin
                if (!input_spike_ready) set_byte(1, 8'($urandom));
                input_spike_ready = ~input_spike_ready;
            end
            if ($urandom_range(0, 49) == 0) begin
                if (!debug_config_ready) set_byte(2, 8'($urandom));
                debug_config_ready = ~debug_config_ready;
            end
            reset = ($urandom_range(0, 999) == 0);
            tick();
        end
        reset = 1'b0;

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/spike_step_sequencer.md
Name: spike_step_sequencer

Overview:
- Downstream consumer of the SPI configuration block, running in the SNN core clock domain.
- Synchronises the three SCLK-domain ready flags and snapshots divider, spike and debug bytes from the 128x8 configuration image.
- Generates the SNN time-step tick and presents one input-spike frame per tick to the network core.

Parameters:
- NUM_BYTES, 128, number of configuration bytes in the image bus.
- CLK_DIV_ADDR, 0, byte index of the time-step divider value.
- SPIKE_ADDR, 1, byte index of the 8-bit input spike frame.
- DEBUG_ADDR, 2, byte index of the debug configuration byte.
- SYNC_STAGES, 2, synchroniser flops per ready flag (minimum 2).

Ports:
- clk  in  1  core clock; sole clock of the block.
- reset  in  1  synchronous, active-high reset.
- all_data_out  in  NUM_BYTES*8  configuration image; byte k = bits [8k+7:8k]. Asynchronous source, quasi-static.
- clk_div_ready  in  1  asynchronous level flag: divider byte valid.
- input_spike_ready  in  1  asynchronous level flag; each rising edge = new spike frame.
- debug_config_ready  in  1  asynchronous level flag: debug byte valid.
- step_en  out  1  one-cycle time-step pulse to the SNN core.
- spikes_out  out  8  spike frame for the current step; valid when step_en=1.
- debug_config  out  8  latched debug byte.
- running  out  1  divider active.
- overrun  out  1  sticky: a pending frame was overwritten before consumption.

Behaviour:
- Reset (sync): every output 0; state IDLE; divider shadow 0; counter 0; pending frame empty; synchronisers cleared.
- Each flag: SYNC_STAGES-flop synchroniser, then a registered edge detector producing rise and fall pulses. Capture occurs on the (SYNC_STAGES+1)th clk edge after the flag is first sampled high.
- Byte capture: the bus is sampled only in the cycle a rise pulse is asserted. The SPI protocol guarantees the byte is stable before its flag rises.
- FSM states: IDLE, RUN.
- IDLE -> RUN on clk_div rise:
  - latch div_shadow = byte[CLK_DIV_ADDR];
  - load count = div_shadow;
  - running = 1 from the next cycle.
- RUN:
  - count decrements each cycle.
  - When count == 0: step_en = 1 and count reloads div_shadow.
  - Step period = div_shadow + 1 cycles (1..256). Divider value 0 gives step_en high every cycle.
  - The first step_en occurs div_shadow + 1 cycles after entering RUN.
- RUN -> IDLE on clk_div fall: running = 0, step_en = 0 immediately; pending frame is retained.
- A clk_div rise while in RUN reloads div_shadow and count (restart); no step_en in that cycle.
- Spike rise: pending = byte[SPIKE_ADDR], pending_valid = 1.
- step_en cycle:
  - spikes_out = pending if pending_valid, else 8'h00 (silent step);
  - pending_valid cleared.
  - spikes_out is registered and returns to 0 the cycle after step_en.
- Simultaneous spike rise and step_en: the step consumes the old pending; the new byte becomes pending. No overrun.
- Spike rise while pending_valid = 1 and no step: overwrite pending and set overrun. overrun is cleared only by reset.
- Debug rise: debug_config = byte[DEBUG_ADDR]; held until the next debug rise or reset. Debug fall has no effect.
- Spike rises in IDLE are still captured; the frame is delivered on the first step.

Optional Feature:
- Macro SPIKE_FIFO_EN.
- When defined, the single pending register is replaced by a 4-entry FIFO:
  - each spike rise pushes one frame;
  - each step_en pops one frame;
  - empty FIFO gives a silent step;
  - a push while full drops the new frame and sets overrun;
  - a simultaneous push and pop while full succeeds.
- When undefined, the single-register overwrite behaviour above applies.

Decomposition:
- Shared package:
  - state enum (IDLE, RUN);
  - default byte offsets CLK_DIV_ADDR, SPIKE_ADDR, DEBUG_ADDR;
  - spike frame width 8;
  - FIFO depth 4.
- One natural sub-module, flag_sync_edge: synchroniser plus rise/fall detector, instantiated three times.

Test Plan:
- Reset check: reset during RUN with count = 5 -> next cycle all outputs 0, state IDLE, no step_en for 20 cycles.
- Divider: byte0 = 8'd3, raise clk_div_ready -> step_en every 4 cycles, first pulse 4 cycles after running rises. byte0 = 0 -> step_en every cycle.
- Spike delivery: byte1 = 8'hA5, raise input_spike_ready -> next step_en carries spikes_out = A5; the following step carries 00.
- Collision: spike rise coincident with step_en while A5 pending -> that step outputs A5; the new byte 3C appears on the next step; overrun stays 0.
- Overrun: two spike rises (11 then 22) within one step period -> step outputs 22, overrun = 1. With SPIKE_FIFO_EN: 11 then 22 on consecutive steps, overrun = 0; a fifth push without a pop -> overrun = 1.
- Debug/stop: byte2 = 8'h5A, raise debug_config_ready -> debug_config = 5A. Drop clk_div_ready -> running = 0 and no further step_en; debug_config still 5A.
